// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: one-cycle arithmetic/logic/compare/shift ops plus iterative shift-add MUL.
// Restoring DIV/REM are built only when MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       ALU_op,
    input  logic             sign_ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] HI,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'b0_0000;
    localparam logic [4:0] OP_SUB  = 5'b0_0001;
    localparam logic [4:0] OP_AND  = 5'b0_0010;
    localparam logic [4:0] OP_OR   = 5'b0_0011;
    localparam logic [4:0] OP_XOR  = 5'b0_0100;
    localparam logic [4:0] OP_NAND = 5'b0_0101;
    localparam logic [4:0] OP_NOR  = 5'b0_0110;
    localparam logic [4:0] OP_XNOR = 5'b0_0111;
    localparam logic [4:0] OP_SLE  = 5'b0_1000;
    localparam logic [4:0] OP_SRA  = 5'b0_1001;
    localparam logic [4:0] OP_SLT  = 5'b0_1010;
    localparam logic [4:0] OP_SGT  = 5'b0_1011;
    localparam logic [4:0] OP_SLL  = 5'b0_1100;
    localparam logic [4:0] OP_SRL  = 5'b0_1101;
    localparam logic [4:0] OP_NEQ  = 5'b0_1110;
    localparam logic [4:0] OP_MUL  = 5'b1_0000;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam logic [4:0] OP_DIV  = 5'b1_0001;
    localparam logic [4:0] OP_REM  = 5'b1_0010;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]              state;
    logic [SHW-1:0]          cnt;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        lo;
    logic [WIDTH-1:0]        opb;
    logic                    neg_res;
    logic                    is_multi;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          shamt;
    logic [WIDTH:0]          add_ext;
    logic [WIDTH:0]          sub_ext;
    logic                    le_s;
    logic                    gt_s;
    logic                    lt_c;
    logic [WIDTH-1:0]        r_out;
    logic                    r_zero;
    logic                    r_ovf;

    logic [WIDTH:0]          mul_sum;
    logic [WIDTH-1:0]        acc_n;
    logic [WIDTH-1:0]        lo_n;
    logic [2*WIDTH-1:0]      mul_prod;
    logic [WIDTH-1:0]        f_out;
    logic [WIDTH-1:0]        f_hi;
    logic                    f_ovf;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic                    is_div_op;
    logic                    div_mode;
    logic                    rem_mode;
    logic                    neg_rem;
    logic                    div0;
    logic                    div_ovf;
    logic [WIDTH-1:0]        a_raw;
    logic [WIDTH:0]          div_shift;
    logic                    div_ge;
    logic [WIDTH-1:0]        div_diff;
`endif

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    // ---- single-cycle datapath: evaluated directly on the live operands ----
    assign sa      = $signed(A);
    assign sb      = $signed(B);
    assign shamt   = A[SHW-1:0];
    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} - {1'b0, B};
    assign le_s    = (sa <= sb);
    assign gt_s    = (sa > sb);
    assign lt_c    = sign_ctrl ? (sa < sb) : (A < B);

    always_comb begin
        r_out  = '0;
        r_zero = 1'b0;
        r_ovf  = 1'b0;
        case (ALU_op)
            OP_ADD: begin
                r_out = add_ext[WIDTH-1:0];
                r_ovf = sign_ctrl ? ((A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]))
                                  : add_ext[WIDTH];
            end
            OP_SUB: begin
                r_out  = sub_ext[WIDTH-1:0];
                r_zero = (sub_ext[WIDTH-1:0] == '0);
                r_ovf  = sign_ctrl ? ((A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]))
                                   : sub_ext[WIDTH];
            end
            OP_AND:  r_out = A & B;
            OP_OR:   r_out = A | B;
            OP_XOR:  r_out = A ^ B;
            OP_NAND: r_out = ~(A & B);
            OP_NOR:  r_out = ~(A | B);
            OP_XNOR: r_out = ~(A ^ B);
            OP_SLE: begin
                r_out  = {{(WIDTH-1){1'b0}}, le_s};
                r_zero = le_s;
            end
            OP_SRA:  r_out = sb >>> shamt;
            OP_SLT:  r_out = {{(WIDTH-1){1'b0}}, lt_c};
            OP_SGT: begin
                r_out  = {{(WIDTH-1){1'b0}}, gt_s};
                r_zero = gt_s;
            end
            OP_SLL:  r_out = B << shamt;
            OP_SRL:  r_out = B >> shamt;
            OP_NEQ:  r_zero = (A != B);
            // unused upper-half codes flag an exception; 0_1111 is a silent no-op
            default: r_ovf = ALU_op[4];
        endcase
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    assign is_div_op = (ALU_op == OP_DIV) || (ALU_op == OP_REM);
    assign is_multi  = (ALU_op == OP_MUL) || is_div_op;
`else
    assign is_multi  = (ALU_op == OP_MUL);
`endif

    // ---- iteration step: {acc,lo} is the product (MUL) or remainder:quotient (DIV) ----
    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);

`ifdef MULTICYCLE_ALU_DIV_EN
    assign div_shift = {acc, lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[WIDTH-1:0] - opb;

    always_comb begin
        if (div_mode) begin
            acc_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], div_ge};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end
`else
    assign acc_n = mul_sum[WIDTH:1];
    assign lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
`endif

    // ---- final sign fix-up, applied on the last iteration ----
    assign mul_prod = cond_neg2({acc_n, lo_n}, neg_res);

    always_comb begin
        f_out = mul_prod[WIDTH-1:0];
        f_hi  = mul_prod[2*WIDTH-1:WIDTH];
        f_ovf = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        if (div_mode) begin
            f_hi  = '0;
            f_ovf = div0 | div_ovf;
            if (div0) begin
                f_out = rem_mode ? a_raw : ALL_ONES;
            end else begin
                f_out = rem_mode ? cond_neg(acc_n, neg_rem) : cond_neg(lo_n, neg_res);
            end
        end
`endif
    end

    // ---- control and architectural outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            OUT      <= '0;
            HI       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_multi) begin
                            state <= CALC;
                        end else begin
                            state    <= DONE;
                            OUT      <= r_out;
                            HI       <= '0;
                            zero     <= r_zero;
                            overflow <= r_ovf;
                        end
                    end
                end
                CALC: begin
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        OUT      <= f_out;
                        HI       <= f_hi;
                        zero     <= 1'b0;
                        overflow <= f_ovf;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---- iterative datapath: operands become magnitudes, sign is restored at the end ----
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (start && is_multi) begin
                cnt     <= '0;
                acc     <= '0;
                lo      <= cond_neg(A, sign_ctrl & A[WIDTH-1]);
                opb     <= cond_neg(B, sign_ctrl & B[WIDTH-1]);
                neg_res <= sign_ctrl & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULTICYCLE_ALU_DIV_EN
                div_mode <= is_div_op;
                rem_mode <= (ALU_op == OP_REM);
                neg_rem  <= sign_ctrl & A[WIDTH-1];
                div0     <= (B == '0);
                div_ovf  <= sign_ctrl && (A == SMIN) && (B == ALL_ONES);
                a_raw    <= A;
`endif
            end
        end else if (state == CALC) begin
            cnt <= cnt + SHW'(1);
            acc <= acc_n;
            lo  <= lo_n;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu at WIDTH=32: vector table, directed multi-cycle sequences and
// random operations against a plain-arithmetic model. Honours MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    alu_op;
    logic          sign_ctrl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  out;
    logic [W-1:0]  hi;
    logic          zero;
    logic          overflow;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALU_op(alu_op), .sign_ctrl(sign_ctrl),
        .A(a), .B(b), .OUT(out), .HI(hi), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [4:0]  op;
        logic        sgn;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] e_out;
        logic [31:0] e_hi;
        logic        e_z;
        logic        e_ovf;
        int          e_lat;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic sgn, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] e_out, input logic [31:0] e_hi,
                           input logic e_z, input logic e_ovf, input int e_lat);
        vec_t v;
        v.op = op; v.sgn = sgn; v.av = av; v.bv = bv;
        v.e_out = e_out; v.e_hi = e_hi; v.e_z = e_z; v.e_ovf = e_ovf; v.e_lat = e_lat;
        tbl.push_back(v);
    endtask

    // Reference behaviour from the arithmetic definitions, using 64-bit integers.
    function automatic void model(input logic [4:0] op, input logic sgn, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] o, output logic [31:0] h,
                                  output logic z, output logic v, output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        o = '0; h = '0; z = 1'b0; v = 1'b0; lat = 1;
        case (op)
            5'h00: begin
                s = sa + sb; p = 64'(av) + 64'(bv); o = p[31:0];
                v = sgn ? (s > SMAX || s < SMIN) : p[32];
            end
            5'h01: begin
                s = sa - sb; o = av - bv; z = (av == bv);
                v = sgn ? (s > SMAX || s < SMIN) : (av < bv);
            end
            5'h02: o = av & bv;
            5'h03: o = av | bv;
            5'h04: o = av ^ bv;
            5'h05: o = ~(av & bv);
            5'h06: o = ~(av | bv);
            5'h07: o = ~(av ^ bv);
            5'h08: begin o = (sa <= sb) ? 32'd1 : 32'd0; z = (sa <= sb); end
            5'h09: begin s = sb >>> av[4:0]; o = 32'(s); end
            5'h0A: o = (sgn ? (sa < sb) : (av < bv)) ? 32'd1 : 32'd0;
            5'h0B: begin o = (sa > sb) ? 32'd1 : 32'd0; z = (sa > sb); end
            5'h0C: o = bv << av[4:0];
            5'h0D: o = bv >> av[4:0];
            5'h0E: z = (av != bv);
            5'h10: begin
                lat = 33;
                if (sgn) begin s = sa * sb; {h, o} = s; end
                else begin p = 64'(av) * 64'(bv); {h, o} = p; end
            end
            5'h11, 5'h12: begin
`ifdef MULTICYCLE_ALU_DIV_EN
                lat = 33;
                if (bv == 0) begin
                    o = (op == 5'h11) ? 32'hFFFF_FFFF : av;
                    v = 1'b1;
                end else if (sgn) begin
                    o = (op == 5'h11) ? 32'(sa / sb) : 32'(sa % sb);
                    v = (sa == SMIN) && (sb == -64'sd1);
                end else begin
                    o = (op == 5'h11) ? (av / bv) : (av % bv);
                end
`else
                v = 1'b1;
`endif
            end
            default: v = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [4:0] op, input logic sgn,
                          input logic [31:0] av, input logic [31:0] bv, input logic [31:0] e_out,
                          input logic [31:0] e_hi, input logic e_z, input logic e_ovf, input int e_lat);
        int lat;
        @(negedge clk);
        alu_op = op; sign_ctrl = sgn; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        alu_op = 5'($urandom); sign_ctrl = 1'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            chk({name, " busy"}, busy, 1'b1);
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        chk({name, " latency"}, lat, e_lat);
        chk({name, " OUT"}, out, e_out);
        chk({name, " HI"}, hi, e_hi);
        chk({name, " zero"}, zero, e_z);
        chk({name, " overflow"}, overflow, e_ovf);
        chk({name, " busy at done"}, busy, 1'b1);
        @(posedge clk); #1;
        chk({name, " done width"}, done, 1'b0);
        chk({name, " idle busy"}, busy, 1'b0);
        chk({name, " OUT held"}, out, e_out);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: begin
                case ($urandom_range(0, 4))
                    0: return 32'h0;
                    1: return 32'h1;
                    2: return 32'hFFFF_FFFF;
                    3: return 32'h8000_0000;
                    default: return 32'h7FFF_FFFF;
                endcase
            end
            1: return 32'($urandom_range(0, 15));
            2: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic        sg;
        logic [31:0] av, bv, eo, eh;
        logic        ez, ev;
        int          el, dones, first_lat;
        logic [31:0] got_out, got_hi;

        rst = 1'b1; start = 1'b0; alu_op = '0; sign_ctrl = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset OUT", out, 0);
        chk("reset HI", hi, 0);
        chk("reset zero", zero, 0);
        chk("reset overflow", overflow, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 1'b0;

        //      op     sgn   A              B              OUT            HI             z     ovf   lat
        add_vec(5'h00, 1'b1, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h00, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h00, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h01, 1'b1, 32'h5,         32'h5,         32'h0,         32'h0,         1'b1, 1'b0, 1);
        add_vec(5'h01, 1'b0, 32'h3,         32'h5,         32'hFFFF_FFFE, 32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h01, 1'b1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h02, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h03, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h04, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h05, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF0F_FF0F, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h06, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h07, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h08, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h1,         32'h0,         1'b1, 1'b0, 1);
        add_vec(5'h08, 1'b1, 32'h5,         32'h4,         32'h0,         32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h09, 1'b0, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h0A, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h0A, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h0B, 1'b0, 32'h1,         32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1);
        add_vec(5'h0C, 1'b0, 32'd31,        32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h0D, 1'b0, 32'd8,         32'h8000_0000, 32'h0080_0000, 32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h0E, 1'b0, 32'h1,         32'h2,         32'h0,         32'h0,         1'b1, 1'b0, 1);
        add_vec(5'h0E, 1'b0, 32'h7,         32'h7,         32'h0,         32'h0,         1'b0, 1'b0, 1);
        add_vec(5'h10, 1'b1, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        add_vec(5'h10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        add_vec(5'h10, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 1'b0, 1'b0, 33);
        add_vec(5'h13, 1'b0, 32'h1234_5678, 32'h9,         32'h0,         32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h1F, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 1'b1, 1);
`ifdef MULTICYCLE_ALU_DIV_EN
        add_vec(5'h11, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'h0,         1'b0, 1'b0, 33);
        add_vec(5'h12, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 33);
        add_vec(5'h11, 1'b0, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 32'h0,         1'b0, 1'b0, 33);
        add_vec(5'h12, 1'b0, 32'hFFFF_FFF9, 32'h2,         32'h1,         32'h0,         1'b0, 1'b0, 33);
        add_vec(5'h11, 1'b0, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 33);
        add_vec(5'h12, 1'b1, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'h0,         1'b0, 1'b1, 33);
        add_vec(5'h11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 33);
        add_vec(5'h12, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 1'b1, 33);
`else
        add_vec(5'h11, 1'b0, 32'd10,        32'd2,         32'h0,         32'h0,         1'b0, 1'b1, 1);
        add_vec(5'h12, 1'b1, 32'd10,        32'd2,         32'h0,         32'h0,         1'b0, 1'b1, 1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].sgn, tbl[i].av, tbl[i].bv,
                   tbl[i].e_out, tbl[i].e_hi, tbl[i].e_z, tbl[i].e_ovf, tbl[i].e_lat);
        end

        // Results hold while idle inputs wander.
        run_op("hold ADD", 5'h00, 1'b0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1);
        for (int c = 0; c < 4; c++) begin
            alu_op = 5'($urandom); a = $urandom; b = $urandom; sign_ctrl = 1'($urandom);
            @(posedge clk); #1;
            chk($sformatf("hold OUT c%0d", c), out, 32'd5);
            chk($sformatf("hold done c%0d", c), done, 1'b0);
        end

        // A start arriving mid-MUL is dropped and never queued.
        @(negedge clk);
        alu_op = 5'h10; sign_ctrl = 1'b1; a = 32'hFFFF_FFFF; b = 32'h3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dones = 0; first_lat = 0; got_out = '0; got_hi = '0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin alu_op = 5'h00; a = 32'h1; b = 32'h1; start = 1'b1; end
            if (c == 7) start = 1'b0;
            if (c <= 33) chk($sformatf("mul busy c%0d", c), busy, 1'b1);
            if (done) begin
                dones++;
                if (dones == 1) begin first_lat = c; got_out = out; got_hi = hi; end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        chk("mul+start done count", dones, 1);
        chk("mul+start latency", first_lat, 33);
        chk("mul+start OUT", got_out, 32'hFFFF_FFFD);
        chk("mul+start HI", got_hi, 32'hFFFF_FFFF);
        chk("mul+start OUT held", out, 32'hFFFF_FFFD);

        // Reset in the middle of a multi-cycle op aborts it; start during reset is ignored.
        @(negedge clk);
`ifdef MULTICYCLE_ALU_DIV_EN
        alu_op = 5'h11;
`else
        alu_op = 5'h10;
`endif
        sign_ctrl = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort busy before rst", busy, 1'b1);
        rst = 1'b1; start = 1'b1; alu_op = 5'h00; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort OUT", out, 32'd0);
        chk("abort HI", hi, 32'd0);
        chk("abort overflow", overflow, 1'b0);
        rst = 1'b0; start = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_vec++;
        chk("abort no done", dones, 0);
        chk("abort OUT after", out, 32'd0);
        run_op("post-abort SUB", 5'h01, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 1);

        // Random operations against the model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 19))
                15: op = 5'h10;
                16: op = 5'h11;
                17: op = 5'h12;
                18, 19: op = 5'($urandom_range(19, 31));
                default: op = 5'($urandom_range(0, 14));
            endcase
            sg = 1'($urandom);
            av = pick_val();
            bv = pick_val();
            model(op, sg, av, bv, eo, eh, ez, ev, el);
            run_op($sformatf("rnd%0d op%02h s%0d A=%h B=%h", i, op, sg, av, bv),
                   op, sg, av, bv, eo, eh, ez, ev, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are 8..64, powers of two.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  launches one operation when idle.
REQ-005 SHALL have port ALU_op  input  5  operation code, sampled at start.
REQ-006 SHALL have port sign_ctrl  input  1  1 = signed operands; 0 = unsigned. Sampled at start.
REQ-007 SHALL have port A  input  WIDTH  operand A, sampled at start.
REQ-008 SHALL have port B  input  WIDTH  operand B, sampled at start.
REQ-009 SHALL have port OUT  output  WIDTH  result (low half for MUL, quotient for DIV, remainder for REM).
REQ-010 SHALL have port HI  output  WIDTH  MUL high half; 0 for all other ops.
REQ-011 SHALL have port zero  output  1  condition flag.
REQ-012 SHALL have port overflow  output  1  overflow/exception flag.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse; results valid.

Function
REQ-015 SHALL have FSM states IDLE, CALC and DONE; start in IDLE with ALU_op[4]=0 -> DONE; start in IDLE with ALU_op[4]=1 -> CALC; CALC -> DONE after WIDTH iterations; DONE -> IDLE unconditionally.
REQ-016 SHALL ignore start unless state is IDLE; start is never queued.
REQ-017 SHALL assert busy in CALC and DONE, and in no other state.
REQ-018 SHALL assert done only in DONE, for exactly one cycle: 1 cycle after start for single-cycle ops, WIDTH+1 cycles after start for MUL/DIV/REM.
REQ-019 SHALL hold OUT, HI, zero and overflow stable from the done cycle until the next accepted start.
REQ-020 SHALL implement single-cycle codes 0_0000 ADD, 0_0001 SUB, 0_0010 AND, 0_0011 OR, 0_0100 XOR, 0_0101 NAND, 0_0110 NOR, 0_0111 XNOR, 0_1000 SLE (signed), 0_1001 SRA, 0_1010 SLT, 0_1011 SGT (signed), 0_1100 SLL, 0_1101 SRL, 0_1110 NEQ.
REQ-021 SHALL compute ADD/SUB overflow as signed overflow when sign_ctrl=1, and as carry-out/borrow when sign_ctrl=0.
REQ-022 SHALL set zero for SUB when the result is 0, for SLE/SGT when the result is 1, and for NEQ when A!=B; for all other ops zero=0.
REQ-023 SHALL, for SLE/SLT/SGT, produce OUT=1 or 0, zero-extended to WIDTH; SLT honours sign_ctrl.
REQ-024 SHALL, for shift ops, shift B by A[$clog2(WIDTH)-1:0]; SRA is arithmetic; NEQ leaves OUT=0.
REQ-025 SHALL implement multicycle code 1_0000 MUL, shift-add, one bit per cycle, producing the full 2*WIDTH product in {HI,OUT}; signed mode uses magnitudes with the sign applied at the end.
REQ-026 SHALL implement multicycle codes 1_0001 DIV and 1_0010 REM, restoring, one bit per cycle; signed results truncate toward zero and the remainder takes the sign of A.
REQ-027 SHALL, when B=0 for DIV/REM, give quotient all-ones and remainder=A, with overflow=1.
REQ-028 SHALL, for signed -2^(WIDTH-1) / -1, give quotient -2^(WIDTH-1) and remainder 0, with overflow=1.
REQ-029 SHALL, for unused codes (1_0011..1_1111), set OUT=0, HI=0 and overflow=1 with 1-cycle latency.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, force state IDLE, OUT=0, HI=0, zero=0, overflow=0, busy=0 and done=0.
REQ-031 SHALL, on rst mid-CALC or in DONE, abort the operation: no done pulse and no result update; start in the cycle with rst=1 is ignored.

Configuration
REQ-032 SHALL use macro MULTICYCLE_ALU_DIV_EN: when defined, DIV/REM are per REQ-026..028; when undefined, the divider logic is absent and 1_0001/1_0010 behave as unused codes per REQ-029.

Verification
REQ-033 WIDTH=32: ADD A=0x7FFFFFFF, B=1, sign_ctrl=1 -> done at +1, OUT=0x80000000, overflow=1.
REQ-034 MUL A=0xFFFFFFFF (-1), B=3, sign_ctrl=1 -> done at +33, {HI,OUT}=0xFFFFFFFF_FFFFFFFD; busy high for 33 cycles.
REQ-035 DIV A=-7, B=2, signed -> OUT=-3; REM on the same operands -> OUT=-1; DIV A=5, B=0 -> OUT=0xFFFFFFFF, overflow=1.
REQ-036 start during MUL busy with ALU_op=ADD -> ignored; the MUL result is unchanged and only one done pulse occurs.
REQ-037 rst asserted at cycle 10 of DIV -> busy=0 next cycle, no done, OUT=0; a new SUB A=B=5 afterwards -> OUT=0, zero=1.
REQ-038 MULTICYCLE_ALU_DIV_EN undefined: DIV A=10, B=2 -> done at +1, OUT=0, overflow=1.
